// File: rtl/button_bounce_gen.sv
// Mechanical-contact emulator: turns a clean requested button level into a
// bouncing output with LFSR-timed segments, then settles on the requested level.
module button_bounce_gen #(
    parameter int unsigned BOUNCE_TIME = 1000000,
    parameter int unsigned MIN_SEG     = 2000,
    parameter int unsigned SEG_BITS    = 12,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic cmd_level,
    input  logic bounce_en,
    output logic btn_output,
    output logic settled_level,
    output logic busy
);

    localparam int unsigned WIN_W = $clog2(BOUNCE_TIME + 1);
    localparam int unsigned SEG_W = $clog2(MIN_SEG + (1 << SEG_BITS));
    localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [WIN_W-1:0] WIN_RELOAD = WIN_W'(BOUNCE_TIME - 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_BOUNCE = 1'b1
    } state_t;

    state_t           state_q;
    logic [15:0]      lfsr_q;
    logic [15:0]      lfsr_d;
    logic [WIN_W-1:0] win_q;
    logic [SEG_W-1:0] seg_q;
    logic [SEG_W-1:0] seg_reload_d;
    logic             target_q;
    logic             btn_q;
    logic             settled_q;
    logic             busy_q;

    // Next LFSR value (x^16+x^14+x^13+x^11+1) and the segment length drawn from the current one
    always_comb begin
        lfsr_d       = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        seg_reload_d = SEG_W'(MIN_SEG) + SEG_W'(lfsr_q[SEG_BITS-1:0]) - SEG_W'(1);
    end

    // Bounce FSM with registered outputs; the window has priority over segment expiry
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            lfsr_q    <= SEED_EFF;
            win_q     <= '0;
            seg_q     <= '0;
            target_q  <= 1'b0;
            btn_q     <= 1'b0;
            settled_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_level != settled_q) begin
                        if (bounce_en) begin
                            state_q  <= ST_BOUNCE;
                            busy_q   <= 1'b1;
                            target_q <= cmd_level;
                            btn_q    <= cmd_level;
                            win_q    <= WIN_RELOAD;
                            seg_q    <= seg_reload_d;
                        end else begin
                            btn_q     <= cmd_level;
                            settled_q <= cmd_level;
                        end
                    end
                end
                ST_BOUNCE: begin
                    // A changed request restarts the whole window from a fresh first contact
                    if (cmd_level != target_q) begin
                        target_q <= cmd_level;
                        btn_q    <= cmd_level;
                        win_q    <= WIN_RELOAD;
                        seg_q    <= seg_reload_d;
                    end else if (win_q == '0) begin
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                        btn_q     <= target_q;
                        settled_q <= target_q;
                    end else begin
                        win_q <= win_q - WIN_W'(1);
                        if (seg_q == '0) begin
                            btn_q <= ~btn_q;
                            seg_q <= seg_reload_d;
                        end else begin
                            seg_q <= seg_q - SEG_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign btn_output    = btn_q;
    assign settled_level = settled_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_button_bounce_gen.sv
// Scoreboard bench for button_bounce_gen: an event-timestamp model predicts every
// cycle's outputs; a negedge monitor pops and compares them against the DUT.
module tb_button_bounce_gen;

    localparam int          BT   = 64;
    localparam int          MS   = 2;
    localparam int          SB   = 3;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int          TBL  = 8192;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic cmd_level = 1'b0;
    logic bounce_en = 1'b0;
    logic btn_output, settled_level, busy;

    button_bounce_gen #(
        .BOUNCE_TIME(BT), .MIN_SEG(MS), .SEG_BITS(SB), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cmd_level(cmd_level), .bounce_en(bounce_en),
        .btn_output(btn_output), .settled_level(settled_level), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic btn;
        logic settled;
        logic busy;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: absolute edge timestamps for window end and next toggle
    logic [15:0] lfsr_tbl[TBL];
    int   m_edge = 0;
    bit   m_bouncing = 1'b0;
    logic m_btn = 1'b0, m_settled = 1'b0, m_target = 1'b0;
    int   m_end = 0, m_tog = 0;

    // Monitor-side bookkeeping
    int   cyc = 0, blen = 0, last_blen = 0, last_tog = 0, tog_cnt = 0;
    bit   prev_busy = 1'b0, rl_chk = 1'b0;
    logic prev_btn = 1'b0;

    // Trace recording for the determinism comparison
    logic trace[2][128];
    int   rec_slot = -1, rec_idx = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    task automatic model(input logic rst, input logic c, input logic en);
        logic [15:0] lf;
        int seg;
        if (!rst) begin
            m_edge = 0; m_bouncing = 1'b0;
            m_btn = 1'b0; m_settled = 1'b0; m_target = 1'b0;
        end else begin
            lf  = lfsr_tbl[m_edge % TBL];
            seg = MS + int'(lf[SB-1:0]);
            if ((m_bouncing && c != m_target) || (!m_bouncing && c != m_settled && en)) begin
                m_bouncing = 1'b1; m_target = c; m_btn = c;
                m_end = m_edge + BT; m_tog = m_edge + seg;
            end else if (!m_bouncing && c != m_settled) begin
                m_btn = c; m_settled = c;
            end else if (m_bouncing && m_edge == m_end) begin
                m_bouncing = 1'b0; m_btn = m_target; m_settled = m_target;
            end else if (m_bouncing && m_edge == m_tog) begin
                m_btn = ~m_btn; m_tog = m_edge + seg;
            end
            m_edge++;
        end
        exp_q.push_back('{btn: m_btn, settled: m_settled, busy: m_bouncing});
    endtask

    task automatic step(input logic rst, input logic c, input logic en);
        @(negedge clk);
        if (rec_slot >= 0 && rec_idx < 128) begin
            trace[rec_slot][rec_idx] = btn_output;
            rec_idx++;
        end
        #1;
        reset_n = rst; cmd_level = c; bounce_en = en;
        model(rst, c, en);
    endtask

    // Monitor: compare each cycle's outputs and measure busy / segment run lengths
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("btn_output", int'(btn_output), int'(e.btn));
            check("settled_level", int'(settled_level), int'(e.settled));
            check("busy", int'(busy), int'(e.busy));
        end
        if (busy === 1'b1) begin
            blen++;
            if (!prev_busy) begin
                last_tog = cyc;
            end else if (btn_output !== prev_btn) begin
                tog_cnt++;
                if (rl_chk) begin
                    check("run_ge_min", int'(cyc - last_tog >= MS), 1);
                    check("run_le_max", int'(cyc - last_tog <= MS + (1 << SB) - 1), 1);
                end
                last_tog = cyc;
            end
        end else if (blen > 0) begin
            last_blen = blen;
            blen = 0;
        end
        prev_busy = (busy === 1'b1);
        prev_btn  = btn_output;
    end

    task automatic run_from_reset(input int slot);
        rec_slot = slot; rec_idx = 0;
        repeat (3) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        repeat (3) step(1'b1, 1'b1, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b0);
        rl_chk = 1'b1; tog_cnt = 0;
        repeat (71) step(1'b1, 1'b1, 1'b1);
        rl_chk = 1'b0;
        rec_slot = -1;
        check("bounce_busy_len", last_blen, BT);
        check("bounce_has_toggle", int'(tog_cnt >= 1), 1);
    endtask

    initial begin
        logic [15:0] v;
        int diffs;
        logic c, en;
        int hold;

        v = SEED;
        for (int i = 0; i < TBL; i++) begin
            lfsr_tbl[i] = v;
            v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
        end

        repeat (5) step(1'b0, 1'b1, 1'b1);
        run_from_reset(0);

        // Retrigger 20 cycles into a bounce
        repeat (2) step(1'b1, 1'b0, 1'b0);
        repeat (20) step(1'b1, 1'b1, 1'b1);
        repeat (90) step(1'b1, 1'b0, 1'b1);
        check("retrigger_busy_len", last_blen, BT + 20);

        // Reset 30 cycles into a bounce, then replay the first run
        repeat (30) step(1'b1, 1'b1, 1'b1);
        repeat (5) step(1'b0, 1'b1, 1'b1);
        run_from_reset(1);
        diffs = 0;
        for (int i = 0; i < 81; i++) begin
            if (trace[0][i] !== trace[1][i]) diffs++;
        end
        check("determinism_diffs", diffs, 0);

        // bounce_en dropped mid-bounce does not abort; next change is pass-through
        repeat (10) step(1'b1, 1'b0, 1'b1);
        repeat (60) step(1'b1, 1'b0, 1'b0);
        check("en_drop_busy_len", last_blen, BT);
        repeat (3) step(1'b1, 1'b1, 1'b0);

        // Randomized levels, enables, hold times and occasional resets
        repeat (40) begin
            c    = 1'($urandom_range(0, 1));
            en   = 1'($urandom_range(0, 1));
            hold = int'($urandom_range(1, 80));
            if ($urandom_range(0, 15) == 0) step(1'b0, c, en);
            repeat (hold) step(1'b1, c, en);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
